// File: rtl/uart_echo_responder.sv
// Echo responder for the UART word link: buffers received words in a small FIFO
// and replays them to the transmitter, substituting NAK_WORD for errored words.
module uart_echo_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] NAK_WORD   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_error,
  input  logic                  echo_en,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           err_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop, push_req, push;
  logic [DATA_WIDTH-1:0] push_word;

  assign push_req  = rx_valid && echo_en;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push      = push_req && ((count != DEPTH_C) || pop);
  assign push_word = rx_error ? NAK_WORD : rx_data;
  assign tx_valid  = (state == SEND);
  assign busy      = (count != '0) || tx_valid;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop        = 1'b1;
        next_state = SEND;
      end
      SEND: if (tx_ready) begin
        if (count != '0) pop = 1'b1;
        else             next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && rx_error && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (push_req && !push && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Receive-side responder for the UART word link. It sits behind the receiver's word output (`valid`/`data`/`error`) and buffers each received word in a small FIFO. It returns each word to the initiator through a transmitter's `valid`/`ready` input. Words received with an error are answered with a fixed NAK word instead of the payload.

## Interface

Parameters:
- `DATA_WIDTH`, 32, word width; must match the receiver and transmitter.
- `FIFO_DEPTH`, 4, number of buffered words; power of two, ≥2.
- `NAK_WORD`, 32'hDEAD_BEEF, word returned for an errored receive; truncated to `DATA_WIDTH`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle pulse: receiver has a complete word.
- `rx_data`  in  DATA_WIDTH  received word, valid when `rx_valid`=1.
- `rx_error`  in  1  parity/framing error for this word, valid when `rx_valid`=1.
- `echo_en`  in  1  1 = accept received words; 0 = ignore them.
- `tx_valid`  out  1  word offered to the transmitter.
- `tx_data`  out  DATA_WIDTH  word to transmit.
- `tx_ready`  in  1  transmitter accepts the word.
- `busy`  out  1  FIFO non-empty or `tx_valid`=1.
- `err_cnt`  out  16  errored words accepted; saturates at 16'hFFFF.
- `drop_cnt`  out  16  words lost because the FIFO was full; saturates at 16'hFFFF.

## Operation

- **Push.** When `rx_valid`=1 and `echo_en`=1, the block writes one entry:
  - `rx_data` if `rx_error`=0;
  - `NAK_WORD` if `rx_error`=1, and `err_cnt` increments.
- **Ignored input.** When `rx_valid`=1 and `echo_en`=0, the word is discarded. No counter changes.
- **Push acceptance.** A push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
- **Drop.** Otherwise the word is dropped and `drop_cnt` increments. An errored word that is dropped increments both `err_cnt` and `drop_cnt`.
- **FIFO structure.** Circular buffer.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Count is `$clog2(FIFO_DEPTH)+1` bits.
  - Order is strict FIFO.
- **Output FSM, state IDLE.**
  - `tx_valid`=0.
  - If count>0: pop the head into the output register and go to SEND.
  - A word pushed in the current cycle is not visible until the next cycle.
- **Output FSM, state SEND.**
  - `tx_valid`=1; `tx_data` holds the output register.
  - A handshake occurs when `tx_valid`=1 and `tx_ready`=1.
  - On a handshake with count>0 (before this cycle's push): pop the next word into the output register and stay in SEND, giving back-to-back transfers.
  - On a handshake with count=0: go to IDLE.
  - With no handshake, `tx_data` and `tx_valid` remain stable.
- **echo_en does not gate output.** Entries already buffered still drain when `echo_en`=0.
- **Counter saturation.** Counters saturate and never wrap. They clear only on reset.

## Timing

- **Reset values.** While `rst_n`=0, all outputs are forced without waiting for a clock edge:
  - `tx_valid`=0, `tx_data`=0, `busy`=0, `err_cnt`=0, `drop_cnt`=0;
  - FIFO empty, FSM in IDLE.
- **Reset mid-operation.** Reset asserted mid-transfer discards the buffered words and the held `tx_data` immediately. There is no completion of the pending word.
- **Latency.** `rx_valid` sampled at edge N, with the FIFO empty and FSM in IDLE:
  - push at edge N;
  - pop at edge N+1;
  - `tx_valid`=1 and `tx_data` valid after edge N+1, i.e. 2 cycles.
- **Throughput.** In SEND with a non-empty FIFO, one word per cycle while `tx_ready`=1.
- **Simultaneous push and pop at full.** Both occur; count stays at `FIFO_DEPTH`; nothing is dropped.
- **Simultaneous push and pop at empty with FSM in SEND.** The handshake with count=0 goes to IDLE. The pushed word is popped at the next edge, which gives one idle cycle.
- **`tx_ready` while `tx_valid`=0.** Ignored.
- **`rx_valid` high for consecutive cycles.** Each cycle is a separate word.
- **`busy`.** Combinational: (count≠0) OR `tx_valid`.

## Test plan

- **Single good word.** After reset, `tx_ready`=1; pulse `rx_valid` with `rx_data`=32'hFCFCEEEB, `rx_error`=0.
  - Required: `tx_valid`=1 with `tx_data`=32'hFCFCEEEB exactly 2 cycles later, for one cycle; `err_cnt`=0.
- **Errored word.** Pulse `rx_valid` with `rx_data`=32'h12345678, `rx_error`=1.
  - Required: `tx_data`=32'hDEADBEEF; `err_cnt`=1; `drop_cnt`=0.
- **Overflow.** `tx_ready`=0; push words 1..6 on consecutive cycles.
  - Required: word 1 is held in the output register; words 2..5 fill the FIFO; word 6 is dropped, so `drop_cnt`=1.
  - Then raise `tx_ready`: output order is 1,2,3,4,5 back-to-back, then `tx_valid`=0 and `busy`=0.
- **Push/pop at full.** FIFO full and `tx_ready`=1; push word A in the same cycle as a handshake.
  - Required: `drop_cnt` unchanged; A is the last word out.
- **echo_en=0.** With 2 words buffered, set `echo_en`=0 and pulse `rx_valid` 3 times.
  - Required: exactly 2 words are output; both counters are unchanged.
- **Reset mid-send.** `tx_valid`=1, `tx_ready`=0, 3 words buffered; assert `rst_n`=0 between clock edges.
  - Required: `tx_valid`=0 and `busy`=0 immediately. After release, no stale word is output.
